// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator.
// SATURATE_EN selects clamping of out_sum instead of wrapping.
package product_accumulator_pkg;

  localparam int PROD_W_DEF  = 128;
  localparam int GUARD_W_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  localparam logic [PROD_W_DEF-1:0] PROD_MAX =
    {1'b0, {(PROD_W_DEF-1){1'b1}}};
  localparam logic [PROD_W_DEF-1:0] PROD_MIN =
    {1'b1, {(PROD_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/product_accumulator_acc_clamp.sv
// ACC_W to PROD_W signed range check with wrap or clamp.
// SATURATE_EN defined: out-of-range sums clamp to the signed limits.
module acc_clamp #(
  parameter int PROD_W  = 128,
  parameter int GUARD_W = 8,
  parameter int ACC_W   = PROD_W + GUARD_W
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [PROD_W-1:0] sum,
  output logic              ovf
);

  localparam logic [PROD_W-1:0] SMAX =
    {1'b0, {(PROD_W-1){1'b1}}};
  localparam logic [PROD_W-1:0] SMIN =
    {1'b1, {(PROD_W-1){1'b0}}};

  logic [GUARD_W:0] hi;

  // in range only when guard bits and PROD_W sign bit agree
  assign hi  = acc[ACC_W-1:PROD_W-1];
  assign ovf = ~((&hi) | ~(|hi));

`ifdef SATURATE_EN
  always_comb begin
    sum = acc[PROD_W-1:0];
    if (ovf) sum = acc[ACC_W-1] ? SMIN : SMAX;
  end
`else
  assign sum = acc[PROD_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Streams signed products into a wide accumulator and emits
// the sum, term count and overflow flag on the last beat.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int GUARD_W = GUARD_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam int ACC_W = PROD_W + GUARD_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               cnt_sat;
  logic               sat_nxt;
  logic               accept;
  logic [PROD_W-1:0]  fin_sum;
  logic               fin_ovf;

  assign in_ready = (state != HOLD);
  assign accept   = in_valid & in_ready;

  // IDLE starts a fresh sum regardless of stale acc/cnt
  assign acc_base = (state == IDLE) ? '0 : acc;
  assign acc_nxt  = acc_base +
    {{GUARD_W{in_product[PROD_W-1]}}, in_product};

  always_comb begin
    cnt_nxt = cnt + 1'b1;
    sat_nxt = cnt_sat;
    if (state == IDLE) begin
      cnt_nxt = CNT_W'(1);
      sat_nxt = 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt_nxt = cnt;
      sat_nxt = 1'b1;
    end
  end

  acc_clamp #(
    .PROD_W  (PROD_W),
    .GUARD_W (GUARD_W),
    .ACC_W   (ACC_W)
  ) u_clamp (
    .acc (acc_nxt),
    .sum (fin_sum),
    .ovf (fin_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      cnt_sat   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (clr) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            cnt_sat <= 1'b0;
          end else if (accept) begin
            if (in_last) begin
              out_sum   <= fin_sum;
              out_count <= cnt_nxt;
              out_ovf   <= sat_nxt | fin_ovf;
              out_valid <= 1'b1;
              state     <= HOLD;
              acc       <= '0;
              cnt       <= '0;
              cnt_sat   <= 1'b0;
            end else begin
              acc     <= acc_nxt;
              cnt     <= cnt_nxt;
              cnt_sat <= sat_nxt;
              state   <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (clr || out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator.
module tb_product_accumulator;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_product;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_sum;
  logic [7:0]   out_count;
  logic         out_ovf;

  int checks = 0;
  int fails  = 0;

  localparam logic [127:0] MAX127 = {1'b0, {127{1'b1}}};

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_count  (out_count),
    .out_ovf    (out_ovf)
  );

  task automatic beat(input logic [127:0] p, input logic l);
    in_valid   = 1'b1;
    in_product = p;
    in_last    = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    in_product = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle_cycle();
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b need 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid: got %b need 0", out_valid);
    end
    checks++;
    if (out_sum !== 128'd0) begin
      fails++; $display("FAIL reset_out_sum: got %0h need 0", out_sum);
    end
    checks++;
    if (out_count !== 8'd0) begin
      fails++; $display("FAIL reset_out_count: got %0d need 0", out_count);
    end
    checks++;
    if (out_ovf !== 1'b0) begin
      fails++; $display("FAIL reset_out_ovf: got %b need 0", out_ovf);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    beat(-128'sd5, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL single_valid: got %b need 1", out_valid);
    end
    checks++;
    if (out_sum !== -128'sd5) begin
      fails++; $display("FAIL single_sum: got %0h need %0h", out_sum, -128'sd5);
    end
    checks++;
    if (out_count !== 8'd1 || out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL single_cnt_ovf: got %0d/%b need 1/0", out_count, out_ovf);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL single_in_ready: got %b need 0", in_ready);
    end
    idle_cycle();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_release: got v=%b r=%b need v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    beat(128'd3, 1'b0);
    beat(128'd7, 1'b0);
    beat(-128'sd2, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 128'd8) begin
      fails++;
      $display("FAIL b2b_sum: got v=%b %0h need v=1 8", out_valid, out_sum);
    end
    checks++;
    if (out_count !== 8'd3) begin
      fails++; $display("FAIL b2b_count: got %0d need 3", out_count);
    end
    n = 0;
    if (!in_ready) n++;
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      if (!in_ready) n++;
    end
    checks++;
    if (n != 1) begin
      fails++; $display("FAIL b2b_bubble: got %0d not-ready cycles need 1", n);
    end
  endtask

  task automatic test_overflow();
    logic [127:0] exp_sum;
`ifdef SATURATE_EN
    exp_sum = MAX127;
`else
    exp_sum = -128'sd2;
`endif
    out_ready = 1'b1;
    beat(MAX127, 1'b0);
    beat(MAX127, 1'b1);
    checks++;
    if (out_ovf !== 1'b1) begin
      fails++; $display("FAIL ovf_flag: got %b need 1", out_ovf);
    end
    checks++;
    if (out_sum !== exp_sum) begin
      fails++; $display("FAIL ovf_sum: got %0h need %0h", out_sum, exp_sum);
    end
    checks++;
    if (out_count !== 8'd2) begin
      fails++; $display("FAIL ovf_count: got %0d need 2", out_count);
    end
    idle_cycle();
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    beat(128'd11, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_sum !== 128'd11 || out_count !== 8'd1 || out_ovf !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable[%0d]: got v=%b r=%b s=%0h c=%0d o=%b need 1 0 b 1 0",
                 i, out_valid, in_ready, out_sum, out_count, out_ovf);
      end
      if (i < 4) idle_cycle();
    end
    out_ready = 1'b1;
    idle_cycle();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_release: got v=%b r=%b need v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_clr();
    out_ready = 1'b1;
    beat(128'd100, 1'b0);
    clr = 1'b1;
    beat(128'd9, 1'b0);
    clr = 1'b0;
    beat(128'd4, 1'b1);
    checks++;
    if (out_sum !== 128'd4 || out_count !== 8'd1) begin
      fails++;
      $display("FAIL clr_result: got %0h/%0d need 4/1", out_sum, out_count);
    end
    checks++;
    if (out_ovf !== 1'b0) begin
      fails++; $display("FAIL clr_ovf: got %b need 0", out_ovf);
    end
    idle_cycle();
    out_ready = 1'b0;
    beat(128'd13, 1'b1);
    clr = 1'b1;
    idle_cycle();
    clr = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL clr_hold: got v=%b r=%b need v=0 r=1", out_valid, in_ready);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_count_sat();
    out_ready = 1'b1;
    for (int i = 0; i < 255; i++) beat(128'd1, 1'b0);
    beat(128'd1, 1'b1);
    checks++;
    if (out_count !== 8'd255) begin
      fails++; $display("FAIL sat_count: got %0d need 255", out_count);
    end
    checks++;
    if (out_ovf !== 1'b1) begin
      fails++; $display("FAIL sat_ovf: got %b need 1", out_ovf);
    end
    checks++;
    if (out_sum !== 128'd256) begin
      fails++; $display("FAIL sat_sum: got %0h need 100", out_sum);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    beat(128'd5, 1'b0);
    beat(128'd5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_sum !== 128'd0 || out_count !== 8'd0 || out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_outs: got %0h/%0d/%b need 0/0/0", out_sum, out_count, out_ovf);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_hs: got v=%b r=%b need v=0 r=1", out_valid, in_ready);
    end
    #1 rst_n = 1'b1;
    idle_cycle();
    beat(128'd6, 1'b1);
    checks++;
    if (out_sum !== 128'd6 || out_count !== 8'd1) begin
      fails++;
      $display("FAIL rstmid_fresh: got %0h/%0d need 6/1", out_sum, out_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_hold();
    test_clr();
    test_count_sat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
